mixed_dir_skid4: RTL
====================

MIXED_DIR_SKID4 -- requirements
Module: mixed_dir_skid4

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per lane.
REQ-002 SHALL have parameter N, default 4: number of independent lanes.
REQ-003 SHALL have port CLK, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port RESET, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port I_valid, input, N: upstream lane k offers data.
REQ-006 SHALL have port I_data, input, N*WIDTH: lane k payload at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port I_ready, output, N: backward signal to upstream; lane k can accept data.
REQ-008 SHALL have port O_valid, output, N: downstream lane k holds data.
REQ-009 SHALL have port O_data, output, N*WIDTH: lane k payload, same packing as I_data.
REQ-010 SHALL have port O_ready, input, N: backward signal from downstream; lane k consumes data. Downstream is the 4-lane slice-rotation stage.

Function
REQ-011 SHALL define per lane k: in_fire = I_valid[k] & I_ready[k]; out_fire = O_valid[k] & O_ready[k].
REQ-012 Lanes SHALL be fully independent; no signal in lane k SHALL depend on another lane.
REQ-013 Each lane SHALL be a 2-entry skid buffer with a main register, a skid register and states EMPTY, ONE, FULL.
REQ-014 I_ready[k] SHALL equal (state != FULL), decoded from state flops only; no combinational path from O_ready to I_ready.
REQ-015 O_valid[k] SHALL equal (state != EMPTY); O_data lane k SHALL equal the main register; no combinational path from I_* to O_*.
REQ-016 EMPTY: in_fire -> ONE, main <= I_data; otherwise stay.
REQ-017 ONE: in_fire & !out_fire -> FULL, skid <= I_data. in_fire & out_fire -> ONE, main <= I_data. !in_fire & out_fire -> EMPTY. Neither -> stay.
REQ-018 FULL: out_fire -> ONE, main <= skid; otherwise stay. in_fire is impossible because I_ready = 0.
REQ-019 Latency SHALL be 1 cycle from in_fire to O_valid when the lane is EMPTY.
REQ-020 Sustained throughput SHALL be 1 word/cycle/lane when O_ready is held at 1.
REQ-021 Data SHALL leave each lane in acceptance order; no word SHALL be dropped or duplicated.
REQ-022 I_valid while I_ready = 0 SHALL be ignored. Upstream keeps I_data stable; the block does not check this.
REQ-023 O_data SHALL hold its value while O_valid = 1 and O_ready = 0.

Reset
REQ-024 RESET = 1 at a clock edge SHALL force every lane to EMPTY regardless of activity. I_ready = all 1 and O_valid = all 0 from the next cycle. Buffered data SHALL be discarded.
REQ-025 Data registers SHALL NOT require reset; O_data is don't-care while O_valid = 0.
REQ-026 Handshakes during the RESET cycle SHALL have no effect.

Structure
REQ-027 A shared package SHALL hold the lane-state enum (EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2) and the default WIDTH/N constants.
REQ-028 The block SHALL instantiate a single-lane sub-module skid_lane, generated N times.

Verification
REQ-029 Reset: assert RESET 2 cycles -> I_ready = 4'b1111 and O_valid = 4'b0000 on the cycle after deassertion.
REQ-030 Pass-through: lane 0 sends 0x11, 0x22, 0x33 on back-to-back cycles with O_ready = 1.
  - O_data lane 0 SHALL show 0x11, 0x22, 0x33 on consecutive cycles starting 1 cycle later.
  - I_ready[0] SHALL stay 1 throughout.
REQ-031 Stall: O_ready[2] = 0 while lane 2 sends 0xA0, 0xA1.
  - Lane 2 SHALL reach FULL and I_ready[2] = 0 the next cycle.
  - After O_ready[2] = 1, O_data SHALL show 0xA0 then 0xA1, and I_ready[2] returns to 1.
REQ-032 Lane isolation: lane 1 is stalled FULL while lanes 0, 2, 3 stream at full rate -> no loss or reorder on lanes 0, 2, 3, and lane 1 data is unchanged.
REQ-033 Reset mid-operation: all lanes FULL, assert RESET one cycle -> all EMPTY next cycle and no stale word ever appears on O_valid.
REQ-034 Random: random I_valid/O_ready at 50% on all lanes for 10k cycles against a per-lane FIFO scoreboard -> zero mismatches, and no I_ready/O_ready combinational dependence (formal or structural check).

Source files
------------

// File: rtl/mixed_dir_skid4_pkg.sv
// Shared types and defaults for the per-lane skid buffer block.
// Lane state encoding and control bundle used by skid_lane.
package mixed_dir_skid4_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N     = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } lane_state_e;

    typedef struct packed {
        logic load_main;
        logic main_from_skid;
        logic load_skid;
    } lane_ctrl_t;

endpackage

// File: rtl/mixed_dir_skid4_skid_lane.sv
// Single-lane 2-entry skid buffer; ready and valid come from state flops only,
// so neither handshake direction has a combinational path through the lane.
module skid_lane
    import mixed_dir_skid4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);

    lane_state_e      state_q;
    lane_state_e      state_d;
    lane_ctrl_t       ctrl;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign up_ready = (state_q != FULL);
    assign dn_valid = (state_q != EMPTY);
    assign dn_data  = main_q;
    assign in_fire  = up_valid & up_ready;
    assign out_fire = dn_valid & dn_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d        = ONE;
                    ctrl.load_main = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_d        = FULL;
                    ctrl.load_skid = 1'b1;
                end else if (in_fire && out_fire) begin
                    ctrl.load_main = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d             = ONE;
                    ctrl.load_main      = 1'b1;
                    ctrl.main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Handshakes seen during reset must not touch the data registers.
        if (RESET) begin
            ctrl = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (ctrl.load_main) begin
            main_q <= ctrl.main_from_skid ? skid_q : up_data;
        end
        if (ctrl.load_skid) begin
            skid_q <= up_data;
        end
    end

endmodule

// File: rtl/mixed_dir_skid4.sv
// N independent skid-buffer lanes between an upstream source and the
// slice-rotation stage; lanes share only clock and reset.
module mixed_dir_skid4
    import mixed_dir_skid4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N-1:0]     I_valid,
    input  logic [N*WIDTH-1:0] I_data,
    output logic [N-1:0]     I_ready,
    output logic [N-1:0]     O_valid,
    output logic [N*WIDTH-1:0] O_data,
    input  logic [N-1:0]     O_ready
);

    for (genvar k = 0; k < N; k++) begin : g_lane
        skid_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .CLK      (CLK),
            .RESET    (RESET),
            .up_valid (I_valid[k]),
            .up_data  (I_data[k*WIDTH +: WIDTH]),
            .up_ready (I_ready[k]),
            .dn_valid (O_valid[k]),
            .dn_data  (O_data[k*WIDTH +: WIDTH]),
            .dn_ready (O_ready[k])
        );
    end

endmodule
